muldiv_iter: RTL and testbench
==============================

MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width; even, >= 4.
REQ-002 SHALL provide parameter CNT_W, default 6, iteration-counter width; 2^CNT_W > WIDTH.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL provide port start  input  1  operation request, qualified by op.
REQ-006 SHALL provide port op  input  4  opcode: 0000 NOP, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO, 0111 MADD, 1000 MADDU, 1001 MSUB, 1010 MSUBU; others NOP.
REQ-007 SHALL provide port cancel  input  1  abort in-flight operation (pipeline flush).
REQ-008 SHALL provide port A  input  WIDTH  rs operand, also MTHI/MTLO source.
REQ-009 SHALL provide port B  input  WIDTH  rt operand.
REQ-010 SHALL provide port hi  output  WIDTH  architectural HI register.
REQ-011 SHALL provide port lo  output  WIDTH  architectural LO register.
REQ-012 SHALL provide port busy  output  1  high while an iterative operation is in flight.
REQ-013 SHALL provide port done  output  1  one-cycle pulse on the edge hi/lo take an iterative result.

Function
REQ-014 SHALL implement states IDLE, CALC, FIN; busy = (state != IDLE), registered.
REQ-015 SHALL accept a request when start=1, state=IDLE, cancel=0, op valid; otherwise ignore start (no queueing).
REQ-016 SHALL on accepted MTHI/MTLO write A into hi/lo at the accept edge, stay IDLE, busy stays 0, done stays 0.
REQ-017 SHALL on accepted mul/div op latch A, B, op, and signedness; load counter with WIDTH; enter CALC.
REQ-018 SHALL in CALC perform one radix-2 step per cycle (shift-add multiply on magnitudes; restoring divide on magnitudes), decrement counter, go to FIN when counter reaches 1 on that edge.
REQ-019 SHALL in FIN apply sign correction, then write hi/lo, pulse done, return to IDLE; busy high exactly WIDTH+1 cycles.
REQ-020 SHALL for MULT/MULTU write {hi,lo} = 2*WIDTH-bit product (signed/unsigned).
REQ-021 SHALL for MADD/MADDU write {hi,lo} = {hi,lo} + product, for MSUB/MSUBU {hi,lo} = {hi,lo} - product, modulo 2^(2*WIDTH), using hi/lo values at FIN.
REQ-022 SHALL for DIV/DIVU write lo = quotient, hi = remainder; signed: quotient truncates toward zero, remainder takes sign of dividend.
REQ-023 SHALL for divide by zero write lo = all ones, hi = A (dividend) unmodified, same latency.
REQ-024 SHALL for DIV with A = most-negative, B = -1 write lo = most-negative, hi = 0.
REQ-025 SHALL treat the most-negative signed operand correctly (magnitude uses WIDTH+1 bits internally).
REQ-026 SHALL on cancel=1 in CALC or FIN return to IDLE next edge, leave hi/lo unchanged, no done pulse.
REQ-027 SHALL give cancel priority over start in the same cycle.
REQ-028 SHALL keep hi/lo stable except at MTHI/MTLO accept or FIN edges.

Reset
REQ-029 SHALL on rst=1 immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, regardless of clk.
REQ-030 SHALL on rst asserted mid-operation discard the operation; first edge after release behaves as IDLE.

Verification
REQ-031 SHALL cover WIDTH=32: MULT A=0xFFFFFFFF, B=2 -> busy 33 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFE, one done pulse.
REQ-032 SHALL cover DIV A=-7 (0xFFFFFFF9), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
REQ-033 SHALL cover MTHI A=5, MTLO A=3, then MADDU A=2, B=4 -> hi=5, lo=11; then MSUBU A=1, B=12 -> hi=4, lo=0xFFFFFFFF.
REQ-034 SHALL cover cancel on 10th CALC cycle of MULT with prior hi=1, lo=2 -> busy falls next edge, hi=1, lo=2, no done.
REQ-035 SHALL cover start asserted during busy and start+cancel in IDLE -> both ignored, hi/lo unchanged.
REQ-036 SHALL cover async rst pulse between clock edges mid-DIV -> hi=lo=0, busy=0 before next edge; WIDTH=8 MULT A=0x80, B=0x80 -> hi=0x40, lo=0x00 after 9 busy cycles.

Source files
------------

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative MIPS-style multiply/divide unit with HI/LO registers.
// One radix-2 step per clock. An accepted multiply or divide keeps busy high
// for WIDTH+1 cycles. MTHI/MTLO complete in a single cycle while the unit stays idle.
// Ports:
//   clk, rst      - clock; asynchronous active-high reset
//   start, op     - request and opcode (NOP/MULT/MULTU/DIV/DIVU/MTHI/MTLO/
//                   MADD/MADDU/MSUB/MSUBU)
//   cancel        - flush an in-flight operation without writing HI/LO
//   A, B          - rs / rt operands (A also feeds MTHI/MTLO)
//   hi, lo        - architectural HI/LO registers
//   busy          - high while an iterative operation is in flight
//   done          - one-cycle pulse after HI/LO take an iterative result
module muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic isSignedOp(input logic [3:0] o);
    return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
  endfunction

  function automatic logic isDivOp(input logic [3:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  logic [1:0]         state, stateNext;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic [3:0]         opR, opNext;
  logic [WIDTH-1:0]   aR, aNext;
  logic [WIDTH-1:0]   magA, magANext;
  logic [WIDTH-1:0]   magB, magBNext;
  logic               negRes, negResNext;
  logic               negRem, negRemNext;
  // acc/low hold {product high, product low} for multiply,
  // {partial remainder, dividend/quotient} for divide.
  logic [WIDTH-1:0]   acc, accNext;
  logic [WIDTH-1:0]   low, lowNext;
  logic [WIDTH-1:0]   hiNext, loNext;
  logic               busyNext, doneNext;

  // Operand magnitudes at accept; an unsigned WIDTH-bit magnitude holds 2^(WIDTH-1).
  logic               inSigned, negAIn, negBIn, opValid;
  logic [WIDTH-1:0]   magAIn, magBIn;

  assign opValid  = (op >= OP_MULT) && (op <= OP_MSUBU);
  assign inSigned = isSignedOp(op);
  assign negAIn   = inSigned & A[WIDTH-1];
  assign negBIn   = inSigned & B[WIDTH-1];
  assign magAIn   = negAIn ? -A : A;
  assign magBIn   = negBIn ? -B : B;

  // One shift-add multiply step.
  logic [WIDTH:0]     mulSum;
  assign mulSum = {1'b0, acc} + {1'b0, (low[0] ? magA : '0)};

  // One restoring divide step on a WIDTH+1-bit shifted remainder.
  logic [WIDTH:0]     divShift, divDiff;
  logic               divGe;
  assign divShift = {acc, low[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, magB};
  assign divGe    = divShift >= {1'b0, magB};

  // Final sign correction and HI/LO merge.
  logic [2*WIDTH-1:0] prodMag, prodRes, hiloCur;
  logic [WIDTH-1:0]   quoRes, remRes;
  assign prodMag = {acc, low};
  assign prodRes = negRes ? -prodMag : prodMag;
  assign hiloCur = {hi, lo};
  assign quoRes  = negRes ? -low : low;
  assign remRes  = negRem ? -acc : acc;

  // Next-state and datapath logic.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    opNext     = opR;
    aNext      = aR;
    magANext   = magA;
    magBNext   = magB;
    negResNext = negRes;
    negRemNext = negRem;
    accNext    = acc;
    lowNext    = low;
    hiNext     = hi;
    loNext     = lo;
    doneNext   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !cancel && opValid) begin
          if (op == OP_MTHI) begin
            hiNext = A;
          end else if (op == OP_MTLO) begin
            loNext = A;
          end else begin
            stateNext  = CALC;
            cntNext    = CNT_LOAD;
            opNext     = op;
            aNext      = A;
            magANext   = magAIn;
            magBNext   = magBIn;
            negResNext = negAIn ^ negBIn;
            negRemNext = negAIn;
            accNext    = '0;
            lowNext    = isDivOp(op) ? magAIn : magBIn;
          end
        end
      end
      CALC: begin
        if (cancel) begin
          stateNext = IDLE;
        end else begin
          if (isDivOp(opR)) begin
            accNext = divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
            lowNext = {low[WIDTH-2:0], divGe};
          end else begin
            accNext = mulSum[WIDTH:1];
            lowNext = {mulSum[0], low[WIDTH-1:1]};
          end
          cntNext = cnt - CNT_ONE;
          if (cnt == CNT_ONE) stateNext = FIN;
        end
      end
      FIN: begin
        stateNext = IDLE;
        if (!cancel) begin
          doneNext = 1'b1;
          case (opR)
            OP_MULT, OP_MULTU: {hiNext, loNext} = prodRes;
            OP_MADD, OP_MADDU: {hiNext, loNext} = hiloCur + prodRes;
            OP_MSUB, OP_MSUBU: {hiNext, loNext} = hiloCur - prodRes;
            OP_DIV, OP_DIVU: begin
              if (magB == '0) begin
                hiNext = aR;
                loNext = '1;
              end else begin
                hiNext = remRes;
                loNext = quoRes;
              end
            end
            default: doneNext = 1'b1;
          endcase
        end
      end
      default: stateNext = IDLE;
    endcase

    busyNext = (stateNext != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      opR    <= '0;
      aR     <= '0;
      magA   <= '0;
      magB   <= '0;
      negRes <= 1'b0;
      negRem <= 1'b0;
      acc    <= '0;
      low    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      opR    <= opNext;
      aR     <= aNext;
      magA   <= magANext;
      magB   <= magBNext;
      negRes <= negResNext;
      negRem <= negRemNext;
      acc    <= accNext;
      low    <= lowNext;
      hi     <= hiNext;
      lo     <= loNext;
      busy   <= busyNext;
      done   <= doneNext;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: scoreboard bench for muldiv_iter at WIDTH=32 and WIDTH=8.
// Stimulus pushes expected {hi,lo} for each iterative op; monitors pop and
// compare on every done pulse.
module tb_muldiv_iter;

  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MADDU = 4'd8;
  localparam logic [3:0] MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start32 = 1'b0, cancel32 = 1'b0;
  logic [3:0]  op32 = NOP;
  logic [31:0] a32 = '0, b32 = '0;
  logic [31:0] hi32, lo32;
  logic        busy32, done32;
  logic        start8 = 1'b0, cancel8 = 1'b0;
  logic [3:0]  op8 = NOP;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  hi8, lo8;
  logic        busy8, done8;

  int nCmp = 0;
  int nBad = 0;
  int doneCnt32 = 0;

  logic [63:0] expQ32[$];
  string       tagQ32[$];
  logic [15:0] expQ8[$];
  string       tagQ8[$];

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32), .CNT_W(6)) u32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .cancel(cancel32),
    .A(a32), .B(b32), .hi(hi32), .lo(lo32), .busy(busy32), .done(done32)
  );

  muldiv_iter #(.WIDTH(8), .CNT_W(4)) u8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .cancel(cancel8),
    .A(a8), .B(b8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 32-bit unit.
  always @(negedge clk) begin
    if (done32) begin
      doneCnt32++;
      if (expQ32.size() == 0) begin
        check("unexpected_done32", {hi32, lo32}, 64'hx);
      end else begin
        logic [63:0] e;
        string t;
        e = expQ32.pop_front();
        t = tagQ32.pop_front();
        check(t, {hi32, lo32}, e);
      end
    end
  end

  // Monitor for the 8-bit unit.
  always @(negedge clk) begin
    if (done8) begin
      if (expQ8.size() == 0) begin
        check("unexpected_done8", 64'({hi8, lo8}), 64'hx);
      end else begin
        logic [15:0] e;
        string t;
        e = expQ8.pop_front();
        t = tagQ8.pop_front();
        check(t, 64'({hi8, lo8}), 64'(e));
      end
    end
  end

  task automatic issue32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start32 = 1'b1; op32 = o; a32 = a; b32 = b;
    @(posedge clk);
    #1;
    start32 = 1'b0; op32 = NOP; a32 = '0; b32 = '0;
  endtask

  task automatic expect32(input logic [31:0] h, input logic [31:0] l, input string t);
    expQ32.push_back({h, l});
    tagQ32.push_back(t);
  endtask

  // Count cycles with busy high; bounded so a stuck busy cannot hang the run.
  task automatic waitBusy32(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy32) n++;
      else break;
    end
  endtask

  int n;
  int doneSnap;

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_hi32", 64'(hi32), 64'h0);
    check("rst_lo32", 64'(lo32), 64'h0);
    check("rst_busy32", 64'(busy32), 64'h0);
    check("rst_done32", 64'(done32), 64'h0);
    check("rst_hilo8", 64'({hi8, lo8}), 64'h0);
    rst = 1'b0;

    // MULT -1 * 2, full latency.
    expect32(32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_neg1x2");
    issue32(MULT, 32'hFFFF_FFFF, 32'd2);
    waitBusy32(n);
    check("mult_busy_cycles", 64'(n), 64'd33);

    // Signed divide -7 / 2.
    expect32(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_by_2");
    issue32(DIV, 32'hFFFF_FFF9, 32'd2);
    waitBusy32(n);
    check("div_busy_cycles", 64'(n), 64'd33);

    // Divide by zero.
    expect32(32'd7, 32'hFFFF_FFFF, "divu_by_zero");
    issue32(DIVU, 32'd7, 32'd0);
    waitBusy32(n);
    check("divz_busy_cycles", 64'(n), 64'd33);

    // MTHI / MTLO single-cycle writes.
    issue32(MTHI, 32'd5, 32'd0);
    check("mthi_hi", 64'(hi32), 64'd5);
    check("mthi_busy", 64'(busy32), 64'd0);
    issue32(MTLO, 32'd3, 32'd0);
    @(negedge clk);
    check("mtlo_lo", 64'(lo32), 64'd3);
    check("mtlo_done", 64'(done32), 64'd0);

    // Accumulate then subtract.
    expect32(32'd5, 32'd11, "maddu_2x4");
    issue32(MADDU, 32'd2, 32'd4);
    waitBusy32(n);
    expect32(32'd4, 32'hFFFF_FFFF, "msubu_1x12");
    issue32(MSUBU, 32'd1, 32'd12);
    waitBusy32(n);

    // Cancel on the 10th CALC cycle of a MULT.
    issue32(MTHI, 32'd1, 32'd0);
    issue32(MTLO, 32'd2, 32'd0);
    doneSnap = doneCnt32;
    issue32(MULT, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #1 cancel32 = 1'b1;
    @(posedge clk);
    #1 cancel32 = 1'b0;
    check("cancel_busy", 64'(busy32), 64'd0);
    repeat (40) @(negedge clk);
    check("cancel_hilo", {hi32, lo32}, {32'd1, 32'd2});
    check("cancel_no_done", 64'(doneCnt32), 64'(doneSnap));

    // Start during busy is ignored.
    expect32(32'd2, 32'd14, "divu_100_by_7");
    issue32(DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start32 = 1'b1; op32 = MTHI; a32 = 32'hDEAD;
    @(posedge clk);
    #1 start32 = 1'b0; op32 = NOP; a32 = '0;
    waitBusy32(n);

    // Start + cancel in IDLE is ignored.
    @(negedge clk);
    start32 = 1'b1; cancel32 = 1'b1; op32 = MTLO; a32 = 32'hBEEF;
    @(posedge clk);
    #1 start32 = 1'b0; cancel32 = 1'b0; op32 = NOP; a32 = '0;
    @(negedge clk);
    check("start_cancel_hilo", {hi32, lo32}, {32'd2, 32'd14});
    check("start_cancel_busy", 64'(busy32), 64'd0);

    // Overflow and most-negative operands.
    expect32(32'd0, 32'h8000_0000, "div_minneg_by_m1");
    issue32(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitBusy32(n);
    expect32(32'h4000_0000, 32'd0, "mult_minneg_sq");
    issue32(MULT, 32'h8000_0000, 32'h8000_0000);
    waitBusy32(n);
    expect32(32'hFFFF_FFFE, 32'h0000_0001, "multu_max_sq");
    issue32(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitBusy32(n);

    // Asynchronous reset between edges mid-DIV.
    issue32(DIV, 32'd100, 32'd3);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_hilo", {hi32, lo32}, 64'h0);
    check("arst_busy", 64'(busy32), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_busy", 64'(busy32), 64'd0);

    // WIDTH=8 signed most-negative square.
    expQ8.push_back(16'h4000);
    tagQ8.push_back("mult8_80x80");
    @(negedge clk);
    start8 = 1'b1; op8 = MULT; a8 = 8'h80; b8 = 8'h80;
    @(posedge clk);
    #1 start8 = 1'b0; op8 = NOP; a8 = '0; b8 = '0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy8) n++;
      else break;
    end
    check("mult8_busy_cycles", 64'(n), 64'd9);

    repeat (4) @(negedge clk);
    check("pending32", 64'(expQ32.size()), 64'd0);
    check("pending8", 64'(expQ8.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
